// File: rtl/seg10_capture.sv
// Receive side of the seg10 display path: synchronises and debounces a one-hot
// 10-line segment bus, decodes it to a digit and flags count-sequence breaks.
module seg10_capture #(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 16,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       segs,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             blank,
  output logic             new_digit,
  output logic             seq_err,
  output logic             pat_err,
  output logic [ERR_W-1:0] err_count,
  output logic             o_dbg_state
);

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           r_state;
  logic [9:0]       r_s1;
  logic [9:0]       r_s2;
  logic [9:0]       r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_digit;
  logic             r_valid;
  logic             r_blank;
  logic             r_new;
  logic             r_seq;
  logic             r_pat;
  logic [ERR_W-1:0] r_err;

  logic [3:0]       w_pop;
  logic [3:0]       w_idx;
  logic [3:0]       w_next;
  logic             w_same;
  logic             w_err_sat;

  // Population count and index of the highest set bit of the candidate.
  always_comb begin
    w_pop = '0;
    w_idx = '0;
    for (int i = 0; i < 10; i++) begin
      if (r_cand[i]) begin
        w_pop = w_pop + 4'd1;
        w_idx = 4'(i);
      end
    end
  end

  assign w_next    = (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
  assign w_same    = (r_s2 == r_cand);
  assign w_err_sat = &r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SETTLE;
      r_s1    <= '0;
      r_s2    <= '0;
      r_cand  <= '0;
      r_cnt   <= '0;
      r_digit <= '0;
      r_valid <= 1'b0;
      r_blank <= 1'b0;
      r_new   <= 1'b0;
      r_seq   <= 1'b0;
      r_pat   <= 1'b0;
      r_err   <= '0;
    end else begin
      r_s1  <= segs;
      r_s2  <= r_s1;
      r_new <= 1'b0;
      r_seq <= 1'b0;
      r_pat <= 1'b0;
      case (r_state)
        SETTLE: begin
          if (!w_same) begin
            r_cand <= r_s2;
            r_cnt  <= CNT_W'(1);
          end else if (r_cnt >= CNT_W'(STABLE_CYCLES)) begin
            r_state <= LOCKED;
            if (w_pop == 4'd0) begin
              r_blank <= 1'b1;
            end else if (w_pop == 4'd1) begin
              r_blank <= 1'b0;
              r_digit <= w_idx;
              r_valid <= 1'b1;
              if (!r_valid || (w_idx != r_digit)) begin
                r_new <= 1'b1;
              end
              // Re-accepting the current digit is never a sequence break.
              if (r_valid && (w_idx != r_digit) && (w_idx != w_next)) begin
                r_seq <= 1'b1;
                if (!w_err_sat) r_err <= r_err + ERR_W'(1);
              end
            end else begin
              r_pat <= 1'b1;
              if (!w_err_sat) r_err <= r_err + ERR_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        LOCKED: begin
          if (!w_same) begin
            r_cand  <= r_s2;
            r_cnt   <= CNT_W'(1);
            r_state <= SETTLE;
          end
        end
        default: r_state <= SETTLE;
      endcase
    end
  end

  assign digit       = r_digit;
  assign digit_valid = r_valid;
  assign blank       = r_blank;
  assign new_digit   = r_new;
  assign seq_err     = r_seq;
  assign pat_err     = r_pat;
  assign err_count   = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seg10_capture.sv
// Directed bench for seg10_capture: table-driven vectors plus hand sequences
// for latency, bounce, saturation and asynchronous reset.
module tb_seg10_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] segs = '0;
  logic [3:0] digit;
  logic       digit_valid;
  logic       blank;
  logic       new_digit;
  logic       seq_err;
  logic       pat_err;
  logic [7:0] err_count;
  logic       dbg_state;

  seg10_capture #(.STABLE_CYCLES(16), .CNT_W(16), .ERR_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .segs        (segs),
    .digit       (digit),
    .digit_valid (digit_valid),
    .blank       (blank),
    .new_digit   (new_digit),
    .seq_err     (seq_err),
    .pat_err     (pat_err),
    .err_count   (err_count),
    .o_dbg_state (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [9:0] segs;
    int         hold;
    logic [3:0] digit;
    logic       valid;
    logic       blank;
    int         n_new;
    int         n_seq;
    int         n_pat;
    logic [7:0] err;
  } vec_t;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cnt_new = 0;
  int         cnt_seq = 0;
  int         cnt_pat = 0;
  logic [3:0] exp_q[$];
  vec_t       tab_a[$];
  vec_t       tab_b[$];

  function automatic vec_t mk(input logic [9:0] s, input int h, input logic [3:0] d,
                              input logic v, input logic b, input int nn, input int ns,
                              input int np, input logic [7:0] e);
    vec_t r;
    r.segs = s; r.hold = h; r.digit = d; r.valid = v; r.blank = b;
    r.n_new = nn; r.n_seq = ns; r.n_pat = np; r.err = e;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance n cycles sampling on the falling edge; new_digit pulses are
  // scored against the expected-digit queue, all pulses are counted.
  task automatic step_cycles(input int n);
    logic [3:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (new_digit) begin
        cnt_new++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL sb_unexpected: new_digit with digit=%0d, no digit expected", digit);
        end else begin
          e = exp_q.pop_front();
          if (digit !== e) begin
            n_errors++;
            $display("FAIL sb_digit: got %0d, expected %0d", digit, e);
          end
        end
      end
      if (seq_err) cnt_seq++;
      if (pat_err) cnt_pat++;
    end
  endtask

  task automatic apply_vec(input vec_t v);
    int n0, s0, p0;
    n0 = cnt_new; s0 = cnt_seq; p0 = cnt_pat;
    segs = v.segs;
    if (v.n_new != 0) exp_q.push_back(v.digit);
    step_cycles(v.hold);
    check("vec_digit", digit, v.digit);
    check("vec_valid", digit_valid, v.valid);
    check("vec_blank", blank, v.blank);
    check("vec_new_cnt", cnt_new - n0, v.n_new);
    check("vec_seq_cnt", cnt_seq - s0, v.n_seq);
    check("vec_pat_cnt", cnt_pat - p0, v.n_pat);
    check("vec_err_count", err_count, v.err);
  endtask

  initial begin
    int lat, found, mism, n0, s0, p0;
    logic [7:0] exp_err;

    // digit steps 1..9, wrap to 0, then up to 2
    for (int d = 1; d <= 9; d++)
      tab_a.push_back(mk(10'(1 << d), 32, 4'(d), 1'b1, 1'b0, 1, 0, 0, 8'd0));
    tab_a.push_back(mk(10'h001, 32, 4'd0, 1'b1, 1'b0, 1, 0, 0, 8'd0));
    tab_a.push_back(mk(10'h002, 32, 4'd1, 1'b1, 1'b0, 1, 0, 0, 8'd0));
    tab_a.push_back(mk(10'h004, 32, 4'd2, 1'b1, 1'b0, 1, 0, 0, 8'd0));
    // after 3: skip, illegal, blank, resume, re-accept, glitch
    tab_b.push_back(mk(10'h020, 32, 4'd5, 1'b1, 1'b0, 1, 1, 0, 8'd1));
    tab_b.push_back(mk(10'h011, 32, 4'd5, 1'b1, 1'b0, 0, 0, 1, 8'd2));
    tab_b.push_back(mk(10'h000, 32, 4'd5, 1'b1, 1'b1, 0, 0, 0, 8'd2));
    tab_b.push_back(mk(10'h040, 32, 4'd6, 1'b1, 1'b0, 1, 0, 0, 8'd2));
    tab_b.push_back(mk(10'h000, 32, 4'd6, 1'b1, 1'b1, 0, 0, 0, 8'd2));
    tab_b.push_back(mk(10'h040, 32, 4'd6, 1'b1, 1'b0, 0, 0, 0, 8'd2));
    tab_b.push_back(mk(10'h300, 32, 4'd6, 1'b1, 1'b0, 0, 0, 1, 8'd3));
    tab_b.push_back(mk(10'h080, 32, 4'd7, 1'b1, 1'b0, 1, 0, 0, 8'd3));
    tab_b.push_back(mk(10'h100, 5,  4'd7, 1'b1, 1'b0, 0, 0, 0, 8'd3));
    tab_b.push_back(mk(10'h080, 32, 4'd7, 1'b1, 1'b0, 0, 0, 0, 8'd3));

    // reset state
    rst_n = 1'b0;
    segs  = '0;
    step_cycles(3);
    check("rst_digit", digit, 0);
    check("rst_valid", digit_valid, 0);
    check("rst_blank", blank, 0);
    check("rst_pulses", {new_digit, seq_err, pat_err}, 0);
    check("rst_err_count", err_count, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    step_cycles(2);

    // first digit: latency from the first sampling edge
    segs = 10'h001;
    exp_q.push_back(4'd0);
    lat = 0;
    found = 0;
    for (int i = 1; i <= 40 && found == 0; i++) begin
      step_cycles(1);
      if (new_digit) begin
        found = 1;
        lat = i;
      end
    end
    check("first_latency", lat, 19);
    check("first_seq_err", seq_err, 0);
    check("first_digit", digit, 0);
    check("first_valid", digit_valid, 1);
    step_cycles(12);
    check("first_err_count", err_count, 0);
    check("first_state_locked", dbg_state, 1);

    foreach (tab_a[i]) apply_vec(tab_a[i]);

    // bounce between 2 and 3 every 5 cycles, then settle on 3
    mism = 0;
    for (int k = 0; k < 20; k++) begin
      segs = (k % 2 == 0) ? 10'h008 : 10'h004;
      for (int c = 0; c < 5; c++) begin
        step_cycles(1);
        if (digit !== 4'd2 || digit_valid !== 1'b1 || blank !== 1'b0 ||
            new_digit !== 1'b0 || seq_err !== 1'b0 || pat_err !== 1'b0)
          mism++;
      end
    end
    check("bounce_outputs_stable", mism, 0);
    n0 = cnt_new; s0 = cnt_seq;
    segs = 10'h008;
    exp_q.push_back(4'd3);
    step_cycles(40);
    check("bounce_digit", digit, 3);
    check("bounce_new_cnt", cnt_new - n0, 1);
    check("bounce_seq_cnt", cnt_seq - s0, 0);
    check("bounce_err_count", err_count, 0);

    foreach (tab_b[i]) apply_vec(tab_b[i]);

    // 300 out-of-sequence digits, counter saturates
    exp_err = 8'd3;
    s0 = cnt_seq; p0 = cnt_pat;
    for (int i = 0; i < 300; i++) begin
      segs = (i % 2 == 0) ? 10'h001 : 10'h004;
      exp_q.push_back((i % 2 == 0) ? 4'd0 : 4'd2);
      if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
      step_cycles(20);
      if (i == 99) check("sat_err_mid", err_count, exp_err);
    end
    check("sat_err_final", err_count, 255);
    check("sat_seq_cnt", cnt_seq - s0, 300);
    check("sat_pat_cnt", cnt_pat - p0, 0);
    check("sat_digit", digit, 2);

    // asynchronous reset in the middle of qualification
    segs = 10'h008;
    step_cycles(8);
    #2 rst_n = 1'b0;
    #1;
    check("arst_digit", digit, 0);
    check("arst_valid", digit_valid, 0);
    check("arst_blank", blank, 0);
    check("arst_pulses", {new_digit, seq_err, pat_err}, 0);
    check("arst_err_count", err_count, 0);
    check("arst_state", dbg_state, 0);
    segs = 10'h000;
    step_cycles(3);
    rst_n = 1'b1;
    n0 = cnt_new; s0 = cnt_seq; p0 = cnt_pat;
    step_cycles(30);
    check("rel_new_cnt", cnt_new - n0, 0);
    check("rel_seq_cnt", cnt_seq - s0, 0);
    check("rel_pat_cnt", cnt_pat - p0, 0);
    check("rel_valid", digit_valid, 0);
    check("rel_digit", digit, 0);
    check("rel_blank", blank, 1);
    check("rel_err_count", err_count, 0);
    check("sb_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg10_capture.md
Name: seg10_capture

Overview:
Receive-side counterpart of the seg10 digit encoder. Samples a 10-line one-hot segment bus (external display lines or an internal loopback), synchronises and debounces it, then decodes it back to a 4-bit digit. Reports whether successive digits follow the 0..9 wrap-around count sequence the display driver produces. Used for board loopback self-test and for bench checking of the display path.

Parameters:
STABLE_CYCLES, 16, consecutive identical synchronised samples required before a pattern is accepted (legal range 2..65535)
CNT_W, 16, width of the internal stability counter; must hold STABLE_CYCLES
ERR_W, 8, width of the saturating error counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset; deassertion synchronous to clk is supplied externally
segs  input  10  segment lines, asynchronous to clk; bit n high means digit n is displayed
digit  output  4  last accepted digit, 0..9
digit_valid  output  1  high once any legal digit has been accepted since reset
blank  output  1  high while the accepted pattern is all-zero
new_digit  output  1  one-cycle pulse when a legal digit is accepted that differs from the previous accepted value
seq_err  output  1  one-cycle pulse: accepted digit is not (previous+1) mod 10
pat_err  output  1  one-cycle pulse: accepted pattern has two or more bits set
err_count  output  ERR_W  count of seq_err plus pat_err events, saturates at all-ones

Behaviour:
- Reset (async, rst_n=0): sync flops=0, stability counter=0, state=SETTLE, digit=0, digit_valid=0, blank=0, new_digit=0, seq_err=0, pat_err=0, err_count=0.
- Synchroniser: two flop stages on all 10 bits (s1, s2). The comparison register cand holds the candidate pattern.
- State SETTLE: if s2==cand, increment counter; else load cand<=s2 and counter<=1. When the counter reaches STABLE_CYCLES, accept cand and go to LOCKED. Counter does not wrap.
- State LOCKED: if s2!=cand, load cand<=s2, counter<=1, go to SETTLE. Otherwise hold. No re-acceptance while the pattern is unchanged.
- Latency: a clean step on segs produces pulses exactly 2+STABLE_CYCLES clock cycles after the first rising edge that samples the new value.
- Acceptance classification, all in the same cycle:
  - all-zero: blank<=1; digit and digit_valid are held; no pulses.
  - exactly one bit n set, n 0..9: blank<=0, digit<=n, digit_valid<=1.
    - If n differs from the previous digit or digit_valid was 0, pulse new_digit.
    - If digit_valid was 1 and n != (digit==9 ? 0 : digit+1), pulse seq_err.
    - The first digit after reset never raises seq_err.
    - Re-accepting the same digit (glitch then return) raises no pulse.
  - two or more bits set: pulse pat_err; digit, digit_valid and blank are held.
- Sequence check uses the last legal digit. Blanks and illegal patterns in between do not reset the expected value.
- err_count: +1 per seq_err pulse and +1 per pat_err pulse; the two cannot occur in the same cycle. Holds at 2^ERR_W-1.
- Bounce: any change before STABLE_CYCLES restarts qualification. No output changes.
- Reset mid-qualification: everything returns to reset values immediately; a pending candidate is discarded.

Test Plan:
1. Reset, then segs=0x001 held 20 cycles (STABLE_CYCLES=16) -> at cycle 18 after the change: digit=0, digit_valid=1, new_digit pulse, seq_err=0, err_count=0.
2. Step segs one-hot 0..9 then 0, each held 32 cycles -> 11 new_digit pulses, digit follows 0..9,0, no seq_err across the 9->0 wrap, err_count=0.
3. After digit=3, apply 0x020 (digit 5) -> seq_err pulse, new_digit pulse, digit=5, err_count=1.
4. After digit=2, toggle segs between 0x004 and 0x008 every 5 cycles for 100 cycles, then hold 0x008 -> no output change during toggling; one new_digit for 3 only after hold, no seq_err.
5. segs=0x011 held -> pat_err pulse, digit unchanged, err_count +1. Then 0x000 -> blank=1, digit held. Then next expected digit -> blank=0, no seq_err.
6. Force 300 mismatched digits with ERR_W=8 -> err_count saturates at 255. Assert rst_n=0 mid-qualification -> all outputs 0 asynchronously, with no pulse on release.
